// File: rtl/toy_lock_param_if.sv
// Grant / accept handshake bundle for the parametrised lock model.
// The master drives requests; the slave (the lock) returns the handshake results.
interface toy_lock_param_if #(
  parameter int EPOCH_WIDTH = 8,
  parameter int NODE_WIDTH  = 2
);
  logic                   grant_valid;
  logic [NODE_WIDTH-1:0]  grant_src;
  logic [NODE_WIDTH-1:0]  grant_dst;
  logic [EPOCH_WIDTH-1:0] grant_epoch;
  logic                   grant_ready;
  logic                   accept_valid;
  logic [NODE_WIDTH-1:0]  accept_node;
  logic [EPOCH_WIDTH-1:0] accept_epoch;
  logic                   accept_drop;
  logic                   accept_done;
  logic                   accept_stale;

  modport master (
    output grant_valid, grant_src, grant_dst, grant_epoch,
    output accept_valid, accept_node, accept_epoch, accept_drop,
    input  grant_ready, accept_done, accept_stale
  );

  modport slave (
    input  grant_valid, grant_src, grant_dst, grant_epoch,
    input  accept_valid, accept_node, accept_epoch, accept_drop,
    output grant_ready, accept_done, accept_stale
  );
endinterface

// File: rtl/toy_lock_param.sv
// Parametrised distributed epoch lock: nodes pass the lock by granting a
// strictly larger epoch to a destination, which takes it by accepting the
// in-flight transfer. A sticky monitor flags two nodes locked on one epoch.
module toy_lock_param #(
  parameter int NUM_NODES   = 4,
  parameter int EPOCH_WIDTH = 8,
  parameter int NODE_WIDTH  = 2,
  parameter int DROP_EN     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  toy_lock_param_if.slave                  lk,
  output logic [NUM_NODES-1:0]             held,
  output logic [NUM_NODES*EPOCH_WIDTH-1:0] ep,
  output logic [NUM_NODES*EPOCH_WIDTH-1:0] transfer,
  output logic [NUM_NODES*EPOCH_WIDTH-1:0] locked,
  output logic [NODE_WIDTH:0]              holder_cnt,
  output logic                             epoch_exhausted,
  output logic                             safe,
  output logic                             violation
);

  typedef logic [EPOCH_WIDTH-1:0] epoch_t;
  localparam epoch_t EPOCH_MAX = '1;

  logic [NUM_NODES-1:0] held_q;
  epoch_t               ep_q       [NUM_NODES];
  epoch_t               transfer_q [NUM_NODES];
  epoch_t               locked_q   [NUM_NODES];
  logic                 done_q;
  logic                 stale_q;
  logic                 exhausted_q;
  logic                 violation_q;

  // One-hot node selects; an out-of-range index selects nothing.
  logic [NUM_NODES-1:0] src_sel, dst_sel, acc_sel;
  logic                 src_held;
  epoch_t               src_ep, acc_tr, acc_ep;
  logic                 grant_ok, acc_match, acc_take, acc_drop;
  logic                 exhaust_now, safe_c;

  // Decode indices and gather the selected node's state.
  always_comb begin
    src_sel  = '0;
    dst_sel  = '0;
    acc_sel  = '0;
    src_held = 1'b0;
    src_ep   = '0;
    acc_tr   = '0;
    acc_ep   = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      src_sel[i] = (lk.grant_src   == NODE_WIDTH'(i));
      dst_sel[i] = (lk.grant_dst   == NODE_WIDTH'(i));
      acc_sel[i] = (lk.accept_node == NODE_WIDTH'(i));
      if (src_sel[i]) begin
        src_held = held_q[i];
        src_ep   = ep_q[i];
      end
      if (acc_sel[i]) begin
        acc_tr = transfer_q[i];
        acc_ep = ep_q[i];
      end
    end
  end

  // Handshake decisions. An all-ones holder can never offer a larger epoch,
  // and a node cannot grant while it is itself accepting.
  always_comb begin
    grant_ok  = lk.grant_valid & (|src_sel) & (|dst_sel) & src_held &
                (lk.grant_epoch > src_ep) &
                ~(lk.accept_valid & (lk.accept_node == lk.grant_src));
    acc_match = lk.accept_valid & (|acc_sel) & (lk.accept_epoch != '0) &
                (acc_tr == lk.accept_epoch);
    acc_take  = acc_match & (lk.accept_epoch > acc_ep);
    acc_drop  = acc_match & lk.accept_drop & (DROP_EN != 0);
  end

  // Safety, exhaustion and holder count from current state.
  always_comb begin
    safe_c      = 1'b1;
    exhaust_now = 1'b0;
    holder_cnt  = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      holder_cnt = holder_cnt + (NODE_WIDTH+1)'(held_q[i]);
      if (held_q[i] && (ep_q[i] == EPOCH_MAX)) exhaust_now = 1'b1;
      for (int j = i + 1; j < NUM_NODES; j++) begin
        if ((locked_q[i] != '0) && (locked_q[i] == locked_q[j])) safe_c = 1'b0;
      end
    end
  end

  // Lock state update; the grant's transfer write lands after the drop clear
  // so it wins when both target the same node.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= NUM_NODES'(1);
      done_q      <= 1'b0;
      stale_q     <= 1'b0;
      exhausted_q <= 1'b0;
      violation_q <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        ep_q[i]       <= (i == 0) ? epoch_t'(1) : '0;
        transfer_q[i] <= '0;
        locked_q[i]   <= '0;
      end
    end else begin
      done_q      <= acc_take;
      stale_q     <= acc_match & ~acc_take;
      exhausted_q <= exhausted_q | exhaust_now;
      violation_q <= violation_q | ~safe_c;
      for (int i = 0; i < NUM_NODES; i++) begin
        if (acc_drop && acc_sel[i])  transfer_q[i] <= '0;
        if (grant_ok && dst_sel[i])  transfer_q[i] <= lk.grant_epoch;
        if (grant_ok && src_sel[i])  held_q[i]     <= 1'b0;
        if (acc_take && acc_sel[i]) begin
          held_q[i]   <= 1'b1;
          ep_q[i]     <= lk.accept_epoch;
          locked_q[i] <= lk.accept_epoch;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_NODES; g++) begin : g_pack
    assign ep[g*EPOCH_WIDTH +: EPOCH_WIDTH]       = ep_q[g];
    assign transfer[g*EPOCH_WIDTH +: EPOCH_WIDTH] = transfer_q[g];
    assign locked[g*EPOCH_WIDTH +: EPOCH_WIDTH]   = locked_q[g];
  end

  assign held            = held_q;
  assign lk.grant_ready  = grant_ok;
  assign lk.accept_done  = done_q;
  assign lk.accept_stale = stale_q;
  assign epoch_exhausted = exhausted_q;
  assign safe            = safe_c;
  assign violation       = violation_q;

endmodule

// File: tb/tb_toy_lock_param.sv
// Bench for toy_lock_param: two instances (4 nodes / 8-bit epochs with drop,
// 3 nodes / 3-bit epochs without drop) against a behavioural lock model.
module tb_toy_lock_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_lock_param_if #(.EPOCH_WIDTH(8), .NODE_WIDTH(2)) a_if ();
  toy_lock_param_if #(.EPOCH_WIDTH(3), .NODE_WIDTH(2)) b_if ();

  logic [3:0]  a_held;
  logic [31:0] a_ep, a_tr, a_lk;
  logic [2:0]  a_cnt;
  logic        a_exh, a_safe, a_viol;
  logic [2:0]  b_held;
  logic [8:0]  b_ep, b_tr, b_lk;
  logic [2:0]  b_cnt;
  logic        b_exh, b_safe, b_viol;

  toy_lock_param #(.NUM_NODES(4), .EPOCH_WIDTH(8), .NODE_WIDTH(2), .DROP_EN(1)) u_a (
    .clk(clk), .rst(rst), .lk(a_if.slave), .held(a_held), .ep(a_ep), .transfer(a_tr),
    .locked(a_lk), .holder_cnt(a_cnt), .epoch_exhausted(a_exh), .safe(a_safe), .violation(a_viol));

  toy_lock_param #(.NUM_NODES(3), .EPOCH_WIDTH(3), .NODE_WIDTH(2), .DROP_EN(0)) u_b (
    .clk(clk), .rst(rst), .lk(b_if.slave), .held(b_held), .ep(b_ep), .transfer(b_tr),
    .locked(b_lk), .holder_cnt(b_cnt), .epoch_exhausted(b_exh), .safe(b_safe), .violation(b_viol));

  int n_chk  = 0;
  int n_fail = 0;

  // Per-instance configuration and model state.
  int NN   [2] = '{4, 3};
  int EMAX [2] = '{255, 7};
  int EW   [2] = '{8, 3};
  int DEN  [2] = '{1, 0};
  int m_held [2][4];
  int m_ep   [2][4];
  int m_tr   [2][4];
  int m_lk   [2][4];
  int m_done [2];
  int m_stale[2];
  int m_exh  [2];
  int m_viol [2];
  int gv[2], gs[2], gd[2], ge[2], av[2], an[2], ae[2], ad[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_held[k][i] = (i == 0) ? 1 : 0;
        m_ep[k][i]   = (i == 0) ? 1 : 0;
        m_tr[k][i]   = 0;
        m_lk[k][i]   = 0;
      end
      m_done[k] = 0; m_stale[k] = 0; m_exh[k] = 0; m_viol[k] = 0;
    end
  endfunction

  function automatic int m_grant(int k);
    if (gv[k] == 0) return 0;
    if (gs[k] >= NN[k] || gd[k] >= NN[k]) return 0;
    if (m_held[k][gs[k]] == 0) return 0;
    if (ge[k] <= m_ep[k][gs[k]]) return 0;
    if (av[k] != 0 && an[k] == gs[k]) return 0;
    return 1;
  endfunction

  function automatic int m_match(int k);
    if (av[k] == 0 || an[k] >= NN[k] || ae[k] == 0) return 0;
    return (m_tr[k][an[k]] == ae[k]) ? 1 : 0;
  endfunction

  function automatic int m_safe(int k);
    for (int i = 0; i < NN[k]; i++)
      for (int j = 0; j < NN[k]; j++)
        if (i != j && m_lk[k][i] != 0 && m_lk[k][i] == m_lk[k][j]) return 0;
    return 1;
  endfunction

  function automatic int m_cnt(int k);
    int c = 0;
    for (int i = 0; i < NN[k]; i++) c += m_held[k][i];
    return c;
  endfunction

  // One clock edge of the lock's rules.
  function automatic void model_edge(int k);
    int gr, mt, take, exh_now, sf;
    gr   = m_grant(k);
    mt   = m_match(k);
    take = (mt != 0 && ae[k] > m_ep[k][an[k]]) ? 1 : 0;
    exh_now = 0;
    for (int i = 0; i < NN[k]; i++)
      if (m_held[k][i] != 0 && m_ep[k][i] == EMAX[k]) exh_now = 1;
    sf = m_safe(k);
    if (mt != 0 && DEN[k] != 0 && ad[k] != 0) m_tr[k][an[k]] = 0;
    if (take != 0) begin
      m_held[k][an[k]] = 1;
      m_ep[k][an[k]]   = ae[k];
      m_lk[k][an[k]]   = ae[k];
    end
    if (gr != 0) begin
      m_tr[k][gd[k]]   = ge[k];
      m_held[k][gs[k]] = 0;
    end
    m_done[k]  = take;
    m_stale[k] = (mt != 0 && take == 0) ? 1 : 0;
    if (exh_now != 0) m_exh[k] = 1;
    if (sf == 0) m_viol[k] = 1;
  endfunction

  function automatic logic [63:0] pk(int k, int sel);
    logic [63:0] v = '0;
    int x;
    for (int i = 0; i < NN[k]; i++) begin
      case (sel)
        0:       x = m_ep[k][i];
        1:       x = m_tr[k][i];
        2:       x = m_lk[k][i];
        default: x = m_held[k][i];
      endcase
      if (sel == 3) v[i] = x[0];
      else          v = v | (64'(x) << (i * EW[k]));
    end
    return v;
  endfunction

  task automatic check_state(input int k);
    if (k == 0) begin
      check("a_held", 64'(a_held), pk(0, 3));
      check("a_ep", 64'(a_ep), pk(0, 0));
      check("a_transfer", 64'(a_tr), pk(0, 1));
      check("a_locked", 64'(a_lk), pk(0, 2));
      check("a_accept_done", 64'(a_if.accept_done), 64'(m_done[0]));
      check("a_accept_stale", 64'(a_if.accept_stale), 64'(m_stale[0]));
      check("a_exhausted", 64'(a_exh), 64'(m_exh[0]));
      check("a_violation", 64'(a_viol), 64'(m_viol[0]));
      check("a_safe", 64'(a_safe), 64'(m_safe(0)));
      check("a_holder_cnt", 64'(a_cnt), 64'(m_cnt(0)));
    end else begin
      check("b_held", 64'(b_held), pk(1, 3));
      check("b_ep", 64'(b_ep), pk(1, 0));
      check("b_transfer", 64'(b_tr), pk(1, 1));
      check("b_locked", 64'(b_lk), pk(1, 2));
      check("b_accept_done", 64'(b_if.accept_done), 64'(m_done[1]));
      check("b_accept_stale", 64'(b_if.accept_stale), 64'(m_stale[1]));
      check("b_exhausted", 64'(b_exh), 64'(m_exh[1]));
      check("b_violation", 64'(b_viol), 64'(m_viol[1]));
      check("b_safe", 64'(b_safe), 64'(m_safe(1)));
      check("b_holder_cnt", 64'(b_cnt), 64'(m_cnt(1)));
    end
  endtask

  task automatic apply();
    a_if.grant_valid  = gv[0][0];     a_if.grant_src    = 2'(gs[0]);
    a_if.grant_dst    = 2'(gd[0]);    a_if.grant_epoch  = 8'(ge[0]);
    a_if.accept_valid = av[0][0];     a_if.accept_node  = 2'(an[0]);
    a_if.accept_epoch = 8'(ae[0]);    a_if.accept_drop  = ad[0][0];
    b_if.grant_valid  = gv[1][0];     b_if.grant_src    = 2'(gs[1]);
    b_if.grant_dst    = 2'(gd[1]);    b_if.grant_epoch  = 3'(ge[1]);
    b_if.accept_valid = av[1][0];     b_if.accept_node  = 2'(an[1]);
    b_if.accept_epoch = 3'(ae[1]);    b_if.accept_drop  = ad[1][0];
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      gv[k] = 0; gs[k] = 0; gd[k] = 0; ge[k] = 0;
      av[k] = 0; an[k] = 0; ae[k] = 0; ad[k] = 0;
    end
  endtask

  task automatic set_g(input int k, input int s, input int d, input int e);
    gv[k] = 1; gs[k] = s; gd[k] = d; ge[k] = e;
  endtask

  task automatic set_a(input int k, input int n, input int e, input int d);
    av[k] = 1; an[k] = n; ae[k] = e; ad[k] = d;
  endtask

  // Apply inputs, check combinational outputs, advance one edge, check state.
  task automatic step();
    apply();
    #1;
    check("a_grant_ready", 64'(a_if.grant_ready), 64'(m_grant(0)));
    check("b_grant_ready", 64'(b_if.grant_ready), 64'(m_grant(1)));
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_state(0);
    check_state(1);
    idle_all();
  endtask

  task automatic do_reset();
    idle_all();
    apply();
    rst = 1'b1;
    #1;
    model_reset();
    check_state(0);
    check_state(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic gen(input int k);
    int h = -1;
    for (int i = 0; i < NN[k]; i++) if (m_held[k][i] != 0) h = i;
    gv[k] = (($urandom % 10) < 6) ? 1 : 0;
    gs[k] = (h >= 0 && ($urandom % 2) == 1) ? h : int'($urandom % 4);
    gd[k] = $urandom % 4;
    if (gs[k] < NN[k] && ($urandom % 10) < 7) ge[k] = (m_ep[k][gs[k]] + int'($urandom % 3)) & EMAX[k];
    else                                      ge[k] = int'($urandom) & EMAX[k];
    av[k] = $urandom % 2;
    an[k] = (($urandom % 5) == 0) ? gs[k] : int'($urandom % 4);
    if (an[k] < NN[k] && ($urandom % 10) < 7) ae[k] = m_tr[k][an[k]];
    else                                      ae[k] = int'($urandom) & EMAX[k];
    ad[k] = $urandom % 2;
  endtask

  initial begin
    rst = 1'b0;
    idle_all();
    do_reset();
    check("reset_held_a", 64'(a_held), 64'h1);

    // Hand the lock 0 -> 2 at epoch 5, then accept with drop.
    set_g(0, 0, 2, 5); step();
    check("t1_transfer2", 64'(a_tr[23:16]), 64'd5);
    check("t1_held", 64'(a_held), 64'h0);
    set_a(0, 2, 5, 1); step();
    check("t2_done", 64'(a_if.accept_done), 64'd1);
    check("t2_locked2", 64'(a_lk[23:16]), 64'd5);
    step();
    check("t2_done_pulse", 64'(a_if.accept_done), 64'd0);
    set_g(0, 2, 1, 5); step();
    set_g(0, 2, 1, 6); step();
    set_a(0, 1, 6, 0); step();
    set_a(0, 1, 6, 0); step();
    check("t3_stale", 64'(a_if.accept_stale), 64'd1);
    check("t3_locked1", 64'(a_lk[15:8]), 64'd6);
    set_g(0, 1, 3, 7); set_a(0, 1, 6, 0); step();
    set_g(0, 1, 3, 7); step();
    set_a(0, 3, 7, 0); step();
    set_g(0, 3, 0, 8); step();
    set_a(0, 0, 8, 0); step();
    set_g(0, 0, 3, 9); set_a(0, 3, 7, 1); step();
    check("t4_transfer3", 64'(a_tr[31:24]), 64'd9);

    // Narrow instance: walk to the top epoch.
    set_g(1, 0, 1, 7); step();
    set_a(1, 1, 7, 0); step();
    step();
    check("t5_exhausted", 64'(b_exh), 64'd1);
    set_g(1, 1, 2, 7); apply(); #1;
    check("t5_no_grant", 64'(b_if.grant_ready), 64'd0);
    step();

    // Randomized traffic with periodic asynchronous resets mid-cycle.
    for (int c = 0; c < 800; c++) begin
      gen(0);
      gen(1);
      step();
      if ((c % 150) == 149) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state(0);
        check_state(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    check("end_b_violation", 64'(b_viol), 64'd0);
    check("end_a_violation", 64'(a_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toy_lock_param.md
# toy_lock_param

Parametrised distributed-lock model for the crafted verification suite. It generalises the fixed four-node epoch lock to `NUM_NODES` nodes and `EPOCH_WIDTH`-bit epochs. It adds a grant/accept handshake, epoch-exhaustion detection, per-node status outputs and a sticky safety monitor. It is a closed model driven by free inputs; the model checker is its consumer through `safe` and `violation`.

## Interface
- `NUM_NODES`, 4: node count, ≥2.
- `EPOCH_WIDTH`, 8: epoch width; epoch 0 means "none".
- `NODE_WIDTH`, 2: node index width, ≥ clog2(`NUM_NODES`).
- `DROP_EN`, 1: 1 enables consumption of transfer messages on accept; 0 leaves messages permanently in flight.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `grant_valid`  in  1: a node requests to grant the lock.
- `grant_src`  in  `NODE_WIDTH`: granting node.
- `grant_dst`  in  `NODE_WIDTH`: destination node.
- `grant_epoch`  in  `EPOCH_WIDTH`: epoch carried by the grant.
- `grant_ready`  out  1: combinational; the grant is taken this cycle.
- `accept_valid`  in  1: a node attempts to accept a transfer.
- `accept_node`  in  `NODE_WIDTH`: accepting node.
- `accept_epoch`  in  `EPOCH_WIDTH`: epoch being accepted.
- `accept_drop`  in  1: consume the matched message (ignored when `DROP_EN`=0).
- `accept_done`  out  1: registered pulse; the previous cycle's accept took the lock.
- `accept_stale`  out  1: registered pulse; the previous cycle's accept matched but was stale.
- `held`  out  `NUM_NODES`: per-node held flag.
- `ep`  out  `NUM_NODES*EPOCH_WIDTH`: per-node current epoch. Node i occupies bits [i*EPOCH_WIDTH +: EPOCH_WIDTH].
- `transfer`  out  `NUM_NODES*EPOCH_WIDTH`: per-node in-flight transfer epoch (0 = none).
- `locked`  out  `NUM_NODES*EPOCH_WIDTH`: per-node last locked epoch.
- `holder_cnt`  out  `NODE_WIDTH+1`: combinational popcount of `held`.
- `epoch_exhausted`  out  1: registered, sticky; a holder has reached epoch all-ones.
- `safe`  out  1: combinational; no two nodes share the same nonzero `locked` value.
- `violation`  out  1: registered, sticky; latched when `safe` is 0 at a clock edge.

## Operation
- Reset state:
  - `held`=1 and `ep`=1 for node 0.
  - `held`=0 and `ep`=0 for all other nodes.
  - All `transfer` and `locked` entries are 0.
  - `accept_done`, `accept_stale`, `epoch_exhausted` and `violation` are 0.
- Grant condition: `grant_ready` = `grant_valid` & `grant_src`<`NUM_NODES` & `grant_dst`<`NUM_NODES` & `held[src]` & `grant_epoch` > `ep[src]` (unsigned) & !(`accept_valid` & `accept_node`==`grant_src`).
- On a taken grant:
  - `transfer[dst]` ← `grant_epoch`.
  - `held[src]` ← 0.
  - Self-grant (`src`==`dst`) is legal.
- Accept match: `accept_valid` & `accept_node`<`NUM_NODES` & `accept_epoch`≠0 & `transfer[node]`==`accept_epoch`.
  - If `DROP_EN` & `accept_drop`: `transfer[node]` ← 0.
  - If `accept_epoch` > `ep[node]`: `held`, `ep` and `locked` of that node take 1, `accept_epoch` and `accept_epoch`; pulse `accept_done` next cycle.
  - Otherwise pulse `accept_stale` next cycle; `held`, `ep` and `locked` are unchanged.
  - A non-matching accept has no effect and no pulse.
- Simultaneous grant and accept:
  - Same node: the grant is blocked (`grant_ready`=0).
  - `grant_dst`==`accept_node`: the grant's write to `transfer` wins over the drop clear. The accept compares against the pre-edge `transfer` value.
- Arithmetic: all epoch comparisons are unsigned at `EPOCH_WIDTH`; there is no wrap. A holder with `ep`=all-ones can never grant.
- `epoch_exhausted` is set on the edge where any node has `held`=1 and `ep`=all-ones.
- Out-of-range indices (≥`NUM_NODES`) are ignored on both channels.

## Timing
- All state updates occur on the `clk` rising edge following the qualifying inputs; latency is 1 cycle.
- `grant_ready`, `holder_cnt` and `safe` are combinational from current state and inputs.
- `accept_done` and `accept_stale` are single-cycle pulses, 1 cycle after the accept.
- `rst` asserted mid-operation immediately restores the reset state, including clearing the sticky flags. There is no pending-update leakage after deassertion.

## Test plan
- Reset, then grant src=0 dst=2 epoch=5 -> `grant_ready`=1; next cycle `held`=0000, `transfer[2]`=5.
- Continue: accept node=2 epoch=5 drop=1 -> next cycle `held[2]`=1, `ep[2]`=`locked[2]`=5, `transfer[2]`=0, `accept_done`=1 for exactly one cycle, `safe`=1.
- Node 2 holding ep=5: grant src=2 epoch=5 -> `grant_ready`=0, state unchanged. Grant epoch=6 to dst=1 with drop=0, accept node=1 epoch=6 twice -> second accept gives `accept_stale`=1; `locked[1]` stays 6.
- Same-cycle grant src=1 and accept node=1 -> `grant_ready`=0. Grant dst=3 epoch=9 with accept node=3 epoch=matching old value and drop=1 -> `transfer[3]`=9 afterwards.
- `EPOCH_WIDTH`=3: walk the lock to epoch 7 -> `epoch_exhausted`=1 next cycle; every further grant gives `grant_ready`=0.
- `DROP_EN`=0 with stale duplicates replayed across nodes: `safe` and `violation` stay 1 and 0. Then assert `rst` mid-sequence -> all outputs return to reset values asynchronously.
